// File: rtl/aes_out_serializer.sv
// aes_out_serializer: output drain for the AES engine.
// Captures every valid engine result into a DEPTH-entry FIFO of {en_de, data}
// and streams each 128-bit block to the host as four 32-bit words, MSB first,
// over a valid/ready interface. Reports dropped results (sticky overflow) and
// counts fully delivered blocks.
// Optional feature macro: AES_OUT_CNT_EN -- when defined, blk_count counts
// delivered blocks; when undefined the counter is removed and blk_count is 0.

package aes_out_pkg;
  typedef struct packed {
    logic         valid;
    logic [127:0] data;
    logic         en_de;
  } out_packet_t;
endpackage

// State table
//   state | meaning
//   IDLE  | no block held; pops the FIFO head as soon as one is available
//   SEND  | block held in shift register; m_valid=1, word idx presented
module aes_out_serializer
  import aes_out_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  out_packet_t pkt_in,
  output logic        m_valid,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        m_en_de,
  input  logic        m_ready,
  input  logic        clr_ovf,
  output logic        full,
  output logic        empty,
  output logic        overflow,
  output logic [15:0] blk_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  logic [128:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_next;
  logic [128:0]   head;

  state_t         state;
  logic [127:0]   shift_q;
  logic [1:0]     idx;

  logic           hs;
  logic           last_hs;
  logic           pop;
  logic           push;
  logic           drop;

  assign hs      = m_valid & m_ready;
  assign last_hs = hs & (idx == 2'd3);
  // The serializer takes a new block when idle or in the same cycle the
  // current block's last word is accepted, so back-to-back blocks have no bubble.
  assign pop     = ~empty & ((state == IDLE) | last_hs);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push    = pkt_in.valid & (~full | pop);
  assign drop    = pkt_in.valid & full & ~pop;
  assign head    = mem[rd_ptr];
  assign m_data  = shift_q[127:96];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CW'(1);
    else if (!push && pop)
      count_next = count - CW'(1);
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {pkt_in.en_de, pkt_in.data};
  end

  // FIFO pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Serializer FSM with registered word outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shift_q <= '0;
      idx     <= 2'd0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_en_de <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state   <= SEND;
            shift_q <= head[127:0];
            m_en_de <= head[128];
            idx     <= 2'd0;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
          end
        end
        SEND: begin
          if (hs) begin
            if (idx == 2'd3) begin
              if (pop) begin
                shift_q <= head[127:0];
                m_en_de <= head[128];
                idx     <= 2'd0;
                m_last  <= 1'b0;
              end else begin
                state   <= IDLE;
                m_valid <= 1'b0;
                m_last  <= 1'b0;
              end
            end else begin
              shift_q <= {shift_q[95:0], 32'h0};
              idx     <= idx + 2'd1;
              m_last  <= (idx == 2'd2);
            end
          end
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
          m_last  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (clr_ovf)
      overflow <= 1'b0;
  end

`ifdef AES_OUT_CNT_EN
  logic [15:0] blk_count_q;

  // Delivered-block counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)
      blk_count_q <= 16'h0000;
    else if (last_hs)
      blk_count_q <= blk_count_q + 16'd1;
  end

  assign blk_count = blk_count_q;
`else
  assign blk_count = 16'h0000;
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
// Self-checking bench for aes_out_serializer: the driver pushes expected
// words into a scoreboard queue, a negedge monitor compares every presented
// word against the queue head and pops on handshake.
module tb_aes_out_serializer;
  import aes_out_pkg::*;

  localparam int DEPTH = 8;
  localparam logic [127:0] KAT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic        clk = 1'b0;
  logic        rst;
  out_packet_t pkt_in;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_en_de;
  logic        m_ready;
  logic        clr_ovf;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [15:0] blk_count;

  // {en_de, last, data}
  logic [33:0] exp_q [$];
  logic [15:0] model_cnt;
  int n_checks = 0;
  int n_fail   = 0;

  aes_out_serializer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .pkt_in    (pkt_in),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_en_de   (m_en_de),
    .m_ready   (m_ready),
    .clr_ovf   (clr_ovf),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .blk_count (blk_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_blk();
`ifdef AES_OUT_CNT_EN
    return model_cnt;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_block(input logic [127:0] d, input logic e);
    for (int w = 0; w < 4; w++)
      exp_q.push_back({e, (w == 3), d[127-32*w -: 32]});
  endtask

  task automatic send(input logic [127:0] d, input logic e, input bit keep);
    if (keep)
      push_block(d, e);
    pkt_in.valid = 1'b1;
    pkt_in.data  = d;
    pkt_in.en_de = e;
    tick();
    pkt_in.valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while ((m_valid || exp_q.size() != 0) && c < budget) begin
      tick();
      c++;
    end
    check("drain_timeout", (c >= budget), 0);
  endtask

  // Monitor: compare each presented word with the scoreboard head.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (!rst && m_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", m_data);
        end else begin
          e = exp_q[0];
          check("word_data", m_data, e[31:0]);
          check("word_last", m_last, e[32]);
          check("word_en_de", m_en_de, e[33]);
          if (m_ready) begin
            void'(exp_q.pop_front());
            if (e[32])
              model_cnt = model_cnt + 16'd1;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    rst       = 1'b1;
    pkt_in    = '0;
    m_ready   = 1'b0;
    clr_ovf   = 1'b0;
    model_cnt = 16'h0000;
    repeat (3) tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_en_de", m_en_de, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_overflow", overflow, 0);
    check("rst_blk_count", blk_count, 0);
    rst = 1'b0;
    tick();

    // Single block, latency of two cycles to first word.
    m_ready = 1'b1;
    send(KAT, 1'b1, 1'b1);
    check("lat_empty_low", empty, 0);
    check("lat_valid_early", m_valid, 0);
    tick();
    check("lat_valid", m_valid, 1);
    check("lat_word0", m_data, 32'h69c4e0d8);
    wait_idle(20);
    check("single_blk_count", blk_count, exp_blk());
    check("single_empty", empty, 1);

    // Backpressure: ready pattern 1,0,0,1 repeating.
    send(KAT, 1'b1, 1'b1);
    cyc = 0;
    while ((m_valid || exp_q.size() != 0) && cyc < 40) begin
      m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      tick();
      cyc++;
    end
    check("bp_timeout", (cyc >= 40), 0);
    m_ready = 1'b1;
    tick();

    // Overflow: DEPTH+2 packets with the host stalled.
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      send(128'(i), i[0], (i <= DEPTH));
      if (i == DEPTH) begin
        check("ovf_full_at_9", full, 1);
        check("ovf_none_at_9", overflow, 0);
      end
    end
    check("ovf_full", full, 1);
    check("ovf_set", overflow, 1);
    pkt_in.valid = 1'b1;
    pkt_in.data  = 128'hdead;
    pkt_in.en_de = 1'b0;
    clr_ovf      = 1'b1;
    tick();
    pkt_in.valid = 1'b0;
    clr_ovf      = 1'b0;
    check("ovf_drop_and_clr", overflow, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);
    m_ready = 1'b1;
    cyc = 0;
    while (m_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check("ovf_drain_cycles", cyc, 36);
    check("ovf_queue_empty", exp_q.size(), 0);
    check("ovf_empty", empty, 1);
    check("ovf_blk_count", blk_count, exp_blk());

    // Full FIFO with a pop and a write in the same cycle.
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++)
      send({32'hc0de0000 + 32'(i), 32'h11111111, 32'h22222222, 32'h33333333}, 1'b1, 1'b1);
    check("fp_full", full, 1);
    m_ready = 1'b1;
    tick();
    tick();
    tick();
    check("fp_word3_last", m_last, 1);
    send(128'hfeedface_0badf00d_12345678_9abcdef0, 1'b0, 1'b1);
    check("fp_no_overflow", overflow, 0);
    check("fp_still_full", full, 1);
    wait_idle(80);
    check("fp_blk_count", blk_count, exp_blk());

    // Reset after word1 of a block, with a second block waiting.
    send(128'h0123456789abcdef_fedcba9876543210, 1'b1, 1'b1);
    send(128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd, 1'b0, 1'b1);
    tick();
    tick();
    rst     = 1'b1;
    m_ready = 1'b0;
    tick();
    exp_q.delete();
    model_cnt = 16'h0000;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_last", m_last, 0);
    check("mid_rst_data", m_data, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_full", full, 0);
    check("mid_rst_blk_count", blk_count, 0);
    rst     = 1'b0;
    m_ready = 1'b1;
    tick();
    send(128'h55555555_66666666_77777777_88888888, 1'b1, 1'b1);
    tick();
    check("post_rst_word0", m_data, 32'h55555555);
    wait_idle(20);
    check("post_rst_blk_count", blk_count, exp_blk());

    // Counter wrap.
`ifdef AES_OUT_CNT_EN
    dut.blk_count_q = 16'hffff;
    model_cnt       = 16'hffff;
    tick();
    check("wrap_preset", blk_count, 16'hffff);
`endif
    send(KAT, 1'b0, 1'b1);
    wait_idle(20);
    check("wrap_blk_count", blk_count, exp_blk());
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
